// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage in front of a 2-bit combinational ALU.
// Requests are queued in a small FIFO. The head request drives the ALU, and the
// ALU result is captured into a valid/ready output register. A carry/borrow flag
// is kept so that chained add/sub requests can use it as their carry-in.
//
// Handshake rules, on both sides: a transfer happens on a rising clk edge where
// valid & ready are both high. A producer keeps valid and its data stable until
// that transfer. ready may depend combinationally on state, but never on valid.
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_a,
    input  logic [1:0] in_b,
    input  logic [2:0] in_op,
    input  logic       in_use_c,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic       alu_cin,
    output logic [2:0] alu_control,
    input  logic [3:0] alu_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic [2:0] out_op,
    output logic       carry_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef struct packed {
        logic       use_c;
        logic [2:0] op;
        logic [1:0] b;
        logic [1:0] a;
    } req_t;

    req_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [3:0]    out_result_q, out_result_d;
    logic [2:0]    out_op_q, out_op_d;
    logic          carry_q, carry_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    req_t head;
    req_t req_in;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign head   = mem_q[rd_ptr_q];
    assign req_in = '{use_c: in_use_c, op: in_op, b: in_b, a: in_a};

    // No push while full, even if a pop frees a slot in the same cycle.
    assign in_ready = ~full & ~rst;
    assign push     = in_valid & in_ready;
    // Issue whenever there is a head and the output register is free or draining.
    assign pop      = ~empty & (~out_valid_q | out_ready);

    // Head request drives the ALU; an empty queue drives all zeros.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_cin     = 1'b0;
        alu_control = '0;
        if (!empty) begin
            alu_a       = head.a;
            alu_b       = head.b;
            alu_cin     = head.use_c & carry_q;
            alu_control = head.op;
        end
    end

    // Next-state for pointers, occupancy, output register and carry flag.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        carry_d      = carry_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_op_d     = head.op;
            if (head.op == OP_ADD) begin
                carry_d = alu_result[2];
            end else if (head.op == OP_SUB) begin
                carry_d = alu_result[3];
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_op_q     <= '0;
            carry_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_op_q     <= out_op_d;
            carry_q      <= carry_d;
        end
    end

    // FIFO storage. It has no reset because the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_in;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_op     = out_op_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl. A small behavioural ALU closes the loop around the
// DUT. A reference model computes each expected {op, result} when the request is
// accepted and queues it. A monitor pops from that queue on every output transfer.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_a = '0;
    logic [1:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       in_use_c = 1'b0;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic       alu_cin;
    logic [2:0] alu_control;
    logic [3:0] alu_result;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_result;
    logic [2:0] out_op;
    logic       carry_flag;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_q[$];
    logic       model_carry = 1'b0;
    logic       rand_on = 1'b0;

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_c(in_use_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_control(alu_control),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op), .carry_flag(carry_flag)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    function automatic logic [3:0] alu_fn(input logic [1:0] a, input logic [1:0] b,
                                          input logic cin, input logic [2:0] op);
        int sa, sb, sc;
        sa = int'(a);
        sb = int'(b);
        sc = int'(cin);
        case (op)
            3'b000:  return {2'b00, a & b};
            3'b001:  return {2'b00, a | b};
            3'b010:  return {2'b00, a ^ b};
            3'b011:  return {2'b00, ~(a & b)};
            3'b100:  return 4'((sa + sb + sc) % 16);
            3'b101:  return 4'((sa - sb - sc + 16) % 16);
            3'b110:  return {2'b00, ~a};
            default: return {a, b};
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_cin, alu_control);

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: requests leave in order, so carry evolves in acceptance order.
    task automatic model_accept(input logic [1:0] a, input logic [1:0] b,
                                input logic [2:0] op, input logic uc);
        logic [3:0] r;
        r = alu_fn(a, b, uc & model_carry, op);
        if (op == 3'b100) model_carry = (int'(a) + int'(b) + int'(uc & model_carry)) >= 4;
        if (op == 3'b101) model_carry = (int'(a) - int'(b) - int'(uc & model_carry)) < 0;
        exp_q.push_back({op, r});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got op=%0d res=%0d with nothing expected",
                         out_op, out_result);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                check("out_op", int'(out_op), int'(e[6:4]));
                check("out_result", int'(out_result), int'(e[3:0]));
            end
        end
    end

    // ---------------- drivers ----------------
    // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
    task automatic push_req(input logic [1:0] a, input logic [1:0] b,
                            input logic [2:0] op, input logic uc);
        bit done = 0;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_op = op; in_use_c = uc;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(a, b, op, uc);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            check("in_ready_in_reset", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        model_carry = 1'b0;
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1;
        end
        if (!done) check("drain_timeout", int'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Reset state.
        do_reset(2);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_result", int'(out_result), 0);
        check("rst_out_op", int'(out_op), 0);
        check("rst_carry", int'(carry_flag), 0);
        check("rst_alu", int'({alu_a, alu_b, alu_cin, alu_control}), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single add 3+2 and two-cycle latency.
        out_ready = 1'b1;
        push_req(2'd3, 2'd2, 3'b100, 1'b0);
        @(negedge clk);
        check("lat_n1_valid", int'(out_valid), 0);
        @(negedge clk);
        check("lat_n2_valid", int'(out_valid), 1);
        check("add_result", int'(out_result), 5);
        check("add_carry", int'(carry_flag), 1);
        @(posedge clk);
        #1;
        wait_drain();

        // Chain: 3+1, then 0+0 with carry-in.
        push_req(2'd3, 2'd1, 3'b100, 1'b0);
        push_req(2'd0, 2'd0, 3'b100, 1'b1);
        @(negedge clk);
        check("chain_head_a", int'(alu_a), 0);
        check("chain_cin", int'(alu_cin), 1);
        @(posedge clk);
        #1;
        wait_drain();
        check("chain_carry_after", int'(carry_flag), 0);

        // Sub 1-2 then AND: borrow set, AND leaves it alone.
        push_req(2'd1, 2'd2, 3'b101, 1'b0);
        push_req(2'd1, 2'd3, 3'b000, 1'b0);
        wait_drain();
        check("sub_borrow_kept", int'(carry_flag), 1);

        // Backpressure: 1 captured + 4 queued.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_req(2'(i), 2'(3 - i), 3'(i + 1), 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_result_stable", int'(out_result), int'(exp_q[0][3:0]));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stream_valid", int'(out_valid), 1);
        end
        @(negedge clk);
        check("bp_stream_end", int'(out_valid), 0);
        check("bp_all_popped", int'(exp_q.size()), 0);
        @(posedge clk);
        #1;

        // Reset mid-operation: 1 captured + 3 queued, carry set beforehand.
        push_req(2'd3, 2'd3, 3'b100, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_req(2'd2, 2'd1, 3'b001, 1'b0);
        idle(1);
        check("pre_rst_carry", int'(carry_flag), 1);
        do_reset(1);
        @(negedge clk);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_carry", int'(carry_flag), 0);
        check("mid_rst_alu", int'({alu_a, alu_b, alu_cin, alu_control}), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_valid", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;

        // Randomised traffic with random backpressure.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    push_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        check("rand_final_carry", int'(carry_flag), int'(model_carry));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
